id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Parametrised operand-fetch stage between decode and execute. It reads the register file for up to NUM_RS source operands and resolves forwarding from NUM_FW prioritised bypass channels. A register scoreboard tracks long-latency writers (load, mul, div) and stalls consumers until their results are available. Resolved operands are held in a valid/ready output register that forms the ID/EX pipeline register.

## Interface
- XLEN, 64, data width
- RF_ADDR_WIDTH, 5, register address width; 2**RF_ADDR_WIDTH scoreboard bits
- NUM_RS, 2, source operands per instruction
- NUM_FW, 3, forwarding channels; index 0 is the youngest producer and has the highest priority
- CNT_WIDTH, 32, stall counter width

Ports:
- clk  in  1  clock; the block uses this single clock only
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs_addr  in  NUM_RS*RF_ADDR_WIDTH  source addresses, packed; operand i is in slice i
- in_rs_used  in  NUM_RS  operand i is read by the instruction
- in_req_rf  in  1  instruction writes rd
- in_rd_addr  in  RF_ADDR_WIDTH  destination register
- in_long_lat  in  1  rd result arrives only through the wb port
- flush  in  1  discards the output register contents
- rf_raddr  out  NUM_RS*RF_ADDR_WIDTH  equals in_rs_addr; combinational
- rf_rdata  in  NUM_RS*XLEN  register-file data; combinational, write-through
- fw_valid  in  NUM_FW  channel carries a register write
- fw_data_ready  in  NUM_FW  channel data is final; 0 means a load is still pending
- fw_rd_addr  in  NUM_FW*RF_ADDR_WIDTH  channel destination
- fw_data  in  NUM_FW*XLEN  channel data
- wb_valid  in  1  long-latency result written back this cycle
- wb_rd_addr  in  RF_ADDR_WIDTH  register whose scoreboard bit is cleared
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  downstream stage accepts
- out_pc, out_rs_data (NUM_RS*XLEN), out_req_rf, out_rd_addr  out  registered copies of the instruction fields and resolved operands
- stall_cycles  out  CNT_WIDTH  count of hazard stall cycles

## Operation
- Each operand i is resolved independently, in this priority order:
  1. Address 0 or in_rs_used[i]=0: value 0, no hazard.
  2. The lowest-index channel j with fw_valid[j] and fw_rd_addr[j] equal to the address is selected. If fw_data_ready[j] is 1, the value is fw_data[j]. If it is 0, the operand has a hazard. Higher-index channels are never consulted once j matches.
  3. The scoreboard bit for the address is set: hazard.
  4. Otherwise the value is rf_rdata[i].
- hazard = in_valid and (any operand has a hazard).
- in_ready = !flush and !hazard and (!out_valid or out_ready).
- fire = in_valid and in_ready.
- On fire, the output register loads all fields and the resolved operands.
- On fire with in_req_rf, in_long_lat and rd≠0, the scoreboard bit for rd is set. The output register also records a private flag, sb_set, for the instruction.
- On wb_valid with wb_rd_addr≠0, the scoreboard bit for wb_rd_addr is cleared.
- Set and clear of the same bit in the same cycle: the set wins, because the new writer is the youngest.
- On flush:
  - out_valid is cleared.
  - If out_valid and sb_set were both 1, that instruction's rd bit is cleared, unless a wb-clear already targets it (idempotent).
  - No fire occurs in the flush cycle.
- Handoff: the output register empties on out_valid and out_ready without fire, and is replaced on the same edge if fire occurs.
- stall_cycles increments by 1 for each cycle with hazard=1 and saturates at all-ones. It is not cleared by flush.
- Bit 0 of the scoreboard is never set.

## Timing
- Latency from fire to out_valid is 1 cycle. Full throughput is 1 instruction per cycle when no hazard exists.
- rf_raddr, hazard and in_ready are combinational from the inputs and state in the same cycle.
- A fw_data_ready 0→1 transition allows fire in that same cycle.
- A wb_valid clear is visible to hazard detection on the next cycle. The register file supplies the written value through write-through in the same cycle as wb, and the bit is still set that cycle, so consumers stall exactly one extra cycle, by design.
- Values after rst (synchronous, active-high):
  - Registers: out_valid=0; out_pc, out_rs_data, out_rd_addr and out_req_rf are 0; scoreboard all 0; sb_set=0; stall_cycles=0.
  - Combinational outputs: in_ready follows its equation and is 1 when in_valid=0.
- rst asserted mid-operation overrides flush, fire and wb in the same cycle.

## Test plan
- Reset, then issue add x3 with x1=5 and x2=7 from the register file, out_ready=1: out_valid rises the next cycle with out_rs_data={7,5}, and stall_cycles stays 0.
- rs1=x4 with fw0 (x4,0xAA,ready=1) and fw1 (x4,0xBB,ready=1) both valid: the operand is 0xAA. Repeat with fw0 ready=0: in_ready=0, stall_cycles increments, and the operand is 0xAA once ready rises.
- Issue a long-latency write to x6, then a consumer of x6: the consumer stalls. Pulse wb (x6) with rf write-through value 0x1234: the consumer fires one cycle later with 0x1234, and stall_cycles equals the number of stalled cycles.
- Issue a long-latency write to x6 and flush while it is still in the output register: out_valid becomes 0, the x6 bit clears, and a later consumer of x6 issues without stall.
- Hold out_ready=0 with out_valid=1: in_ready=0 and the outputs stay stable. Raise out_ready with a new in_valid: handoff and load happen on the same edge.
- Operand x0 with fw0 targeting x0: the operand is 0 and no hazard is raised.

Source files
------------

// File: rtl/id_operand_stage.sv
// Operand fetch between decode and execute: bypass/RF operand resolution, long-latency
// scoreboard stalls, and a one-deep valid/ready ID/EX output register (1-cycle latency).
module id_operand_stage #(
  parameter int XLEN          = 64,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int NUM_RS        = 2,
  parameter int NUM_FW        = 3,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [XLEN-1:0]                 in_pc,
  input  logic [NUM_RS*RF_ADDR_WIDTH-1:0] in_rs_addr,
  input  logic [NUM_RS-1:0]               in_rs_used,
  input  logic                            in_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0]        in_rd_addr,
  input  logic                            in_long_lat,
  input  logic                            flush,
  output logic [NUM_RS*RF_ADDR_WIDTH-1:0] rf_raddr,
  input  logic [NUM_RS*XLEN-1:0]          rf_rdata,
  input  logic [NUM_FW-1:0]               fw_valid,
  input  logic [NUM_FW-1:0]               fw_data_ready,
  input  logic [NUM_FW*RF_ADDR_WIDTH-1:0] fw_rd_addr,
  input  logic [NUM_FW*XLEN-1:0]          fw_data,
  input  logic                            wb_valid,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rd_addr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [XLEN-1:0]                 out_pc,
  output logic [NUM_RS*XLEN-1:0]          out_rs_data,
  output logic                            out_req_rf,
  output logic [RF_ADDR_WIDTH-1:0]        out_rd_addr,
  output logic [CNT_WIDTH-1:0]            stall_cycles
);
  localparam int NREG = 2 ** RF_ADDR_WIDTH;

  logic [NREG-1:0]          sb_q, sb_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sb_set_q, sb_set_d;
  logic [XLEN-1:0]          out_pc_q;
  logic [NUM_RS*XLEN-1:0]   out_rs_data_q;
  logic                     out_req_rf_q;
  logic [RF_ADDR_WIDTH-1:0] out_rd_addr_q;
  logic [CNT_WIDTH-1:0]     stall_q, stall_d;

  logic [NUM_RS*XLEN-1:0]   opnd;
  logic [NUM_RS-1:0]        op_haz;
  logic [RF_ADDR_WIDTH-1:0] rs_a;
  logic                     fw_hit;
  logic                     hazard, fire, set_sb;

  assign rf_raddr = in_rs_addr;

  // Lowest matching bypass channel wins outright, even if its data is not final yet.
  always_comb begin
    opnd   = '0;
    op_haz = '0;
    rs_a   = '0;
    fw_hit = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      rs_a   = in_rs_addr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
      fw_hit = 1'b0;
      if (in_rs_used[i] && rs_a != '0) begin
        for (int j = 0; j < NUM_FW; j++) begin
          if (!fw_hit && fw_valid[j] &&
              fw_rd_addr[j*RF_ADDR_WIDTH +: RF_ADDR_WIDTH] == rs_a) begin
            fw_hit = 1'b1;
            if (fw_data_ready[j]) opnd[i*XLEN +: XLEN] = fw_data[j*XLEN +: XLEN];
            else                  op_haz[i] = 1'b1;
          end
        end
        if (!fw_hit) begin
          if (sb_q[rs_a]) op_haz[i] = 1'b1;
          else            opnd[i*XLEN +: XLEN] = rf_rdata[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign hazard   = in_valid && (|op_haz);
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign set_sb   = fire && in_req_rf && in_long_lat && (in_rd_addr != '0);

  // A new long-latency writer is the youngest, so its set overrides any clear.
  always_comb begin
    sb_d = sb_q;
    if (flush && out_valid_q && sb_set_q) sb_d[out_rd_addr_q] = 1'b0;
    if (wb_valid && wb_rd_addr != '0)     sb_d[wb_rd_addr]    = 1'b0;
    if (set_sb)                           sb_d[in_rd_addr]    = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sb_set_d    = sb_set_q;
    if (flush) begin
      out_valid_d = 1'b0;
      sb_set_d    = 1'b0;
    end else if (fire) begin
      out_valid_d = 1'b1;
      sb_set_d    = set_sb;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      sb_set_d    = 1'b0;
    end
    stall_d = (hazard && stall_q != '1) ? stall_q + CNT_WIDTH'(1) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q          <= '0;
      out_valid_q   <= 1'b0;
      sb_set_q      <= 1'b0;
      out_pc_q      <= '0;
      out_rs_data_q <= '0;
      out_req_rf_q  <= 1'b0;
      out_rd_addr_q <= '0;
      stall_q       <= '0;
    end else begin
      sb_q        <= sb_d;
      out_valid_q <= out_valid_d;
      sb_set_q    <= sb_set_d;
      stall_q     <= stall_d;
      if (fire) begin
        out_pc_q      <= in_pc;
        out_rs_data_q <= opnd;
        out_req_rf_q  <= in_req_rf;
        out_rd_addr_q <= in_rd_addr;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_rs_data  = out_rs_data_q;
  assign out_req_rf   = out_req_rf_q;
  assign out_rd_addr  = out_rd_addr_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: operand-resolution vector table, directed hazard sequences,
// then randomized traffic against a register-level reference model.
module tb_id_operand_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [63:0]  in_pc;
  logic [9:0]   in_rs_addr, rf_raddr;
  logic [1:0]   in_rs_used;
  logic         in_req_rf;
  logic [4:0]   in_rd_addr;
  logic         in_long_lat, flush;
  logic [127:0] rf_rdata;
  logic [2:0]   fw_valid, fw_data_ready;
  logic [14:0]  fw_rd_addr;
  logic [191:0] fw_data;
  logic         wb_valid;
  logic [4:0]   wb_rd_addr;
  logic         out_valid, out_ready;
  logic [63:0]  out_pc;
  logic [127:0] out_rs_data;
  logic         out_req_rf;
  logic [4:0]   out_rd_addr;
  logic [31:0]  stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit [31:0]    m_busy;
  bit           m_ov, m_sbset, m_req;
  logic [63:0]  m_pc;
  logic [127:0] m_ops;
  logic [4:0]   m_rd;
  logic [31:0]  m_stall;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs_addr(in_rs_addr), .in_rs_used(in_rs_used), .in_req_rf(in_req_rf),
    .in_rd_addr(in_rd_addr), .in_long_lat(in_long_lat), .flush(flush),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fw_valid(fw_valid),
    .fw_data_ready(fw_data_ready), .fw_rd_addr(fw_rd_addr), .fw_data(fw_data),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs_data(out_rs_data),
    .out_req_rf(out_req_rf), .out_rd_addr(out_rd_addr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_rs_addr = '0; in_rs_used = '0;
    in_req_rf = 1'b0; in_rd_addr = '0; in_long_lat = 1'b0; flush = 1'b0;
    rf_rdata = '0; fw_valid = '0; fw_data_ready = '0; fw_rd_addr = '0; fw_data = '0;
    wb_valid = 1'b0; wb_rd_addr = '0; out_ready = 1'b1;
  endtask

  task automatic set_instr(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [1:0] used, input logic req, input logic [4:0] rd,
                           input logic lng);
    in_valid = 1'b1; in_pc = pc; in_rs_addr = {rs2, rs1}; in_rs_used = used;
    in_req_rf = req; in_rd_addr = rd; in_long_lat = lng;
  endtask

  task automatic set_fw(input int j, input logic v, input logic r, input logic [4:0] a,
                        input logic [63:0] d);
    fw_valid[j] = v; fw_data_ready[j] = r;
    fw_rd_addr[j*5 +: 5] = a; fw_data[j*64 +: 64] = d;
  endtask

  // Operand value/hazard straight from the priority rules.
  function automatic void model_resolve(input int i, output logic [63:0] val, output bit haz);
    logic [4:0] a;
    a = in_rs_addr[i*5 +: 5];
    val = '0;
    haz = 1'b0;
    if (!in_rs_used[i] || a == 5'd0) return;
    for (int j = 0; j < 3; j++) begin
      if (fw_valid[j] && fw_rd_addr[j*5 +: 5] == a) begin
        if (fw_data_ready[j]) val = fw_data[j*64 +: 64];
        else                  haz = 1'b1;
        return;
      end
    end
    if (m_busy[a]) haz = 1'b1;
    else           val = rf_rdata[i*64 +: 64];
  endfunction

  // Inputs are already applied; check combinational outputs, clock once, check registers.
  task automatic step();
    logic [63:0] v0, v1;
    bit h0, h1, hz, rdy, fire;
    #1;
    model_resolve(0, v0, h0);
    model_resolve(1, v1, h1);
    hz   = in_valid && (h0 || h1);
    rdy  = !flush && !hz && (!m_ov || out_ready);
    fire = in_valid && rdy;
    chk("in_ready", in_ready, rdy);
    chk("rf_raddr", rf_raddr, in_rs_addr);
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_ov = 0; m_sbset = 0; m_pc = '0; m_ops = '0;
      m_req = 0; m_rd = '0; m_stall = '0;
    end else begin
      if (hz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush && m_ov && m_sbset) m_busy[m_rd] = 1'b0;
      if (wb_valid && wb_rd_addr != 0) m_busy[wb_rd_addr] = 1'b0;
      if (fire && in_req_rf && in_long_lat && in_rd_addr != 0) m_busy[in_rd_addr] = 1'b1;
      if (flush) begin
        m_ov = 0; m_sbset = 0;
      end else if (fire) begin
        m_ov = 1; m_sbset = in_req_rf && in_long_lat && in_rd_addr != 0;
        m_pc = in_pc; m_ops = {v1, v0}; m_req = in_req_rf; m_rd = in_rd_addr;
      end else if (out_ready) begin
        m_ov = 0; m_sbset = 0;
      end
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("stall_cycles", stall_cycles, m_stall);
    if (m_ov) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_rs_data", out_rs_data, m_ops);
      chk("out_req_rf", out_req_rf, m_req);
      chk("out_rd_addr", out_rd_addr, m_rd);
    end
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [1:0]  used;
    logic [63:0] rf1, rf2;
    logic [2:0]  fwv, fwr;
    logic [4:0]  fwa0, fwa1, fwa2;
    logic [63:0] fwd0, fwd1, fwd2;
    logic        exp_rdy;
    logic [63:0] exp1, exp2;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] base;

  initial begin
    vecs[0] = '{5'd1, 5'd2, 2'b11, 64'd5, 64'd7, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0,
                64'h0, 64'h0, 64'h0, 1'b1, 64'd5, 64'd7};
    vecs[1] = '{5'd4, 5'd9, 2'b11, 64'h44, 64'h99, 3'b011, 3'b011, 5'd4, 5'd4, 5'd0,
                64'hAA, 64'hBB, 64'h0, 1'b1, 64'hAA, 64'h99};
    vecs[2] = '{5'd4, 5'd9, 2'b11, 64'h44, 64'h99, 3'b011, 3'b010, 5'd4, 5'd4, 5'd0,
                64'hAA, 64'hBB, 64'h0, 1'b0, 64'h0, 64'h0};
    vecs[3] = '{5'd0, 5'd5, 2'b11, 64'h11, 64'h55, 3'b011, 3'b010, 5'd0, 5'd5, 5'd0,
                64'hDEAD, 64'hCC, 64'h0, 1'b1, 64'h0, 64'hCC};
    vecs[4] = '{5'd3, 5'd7, 2'b01, 64'h33, 64'h77, 3'b001, 3'b000, 5'd7, 5'd0, 5'd0,
                64'h70, 64'h0, 64'h0, 1'b1, 64'h33, 64'h0};
    vecs[5] = '{5'd8, 5'd10, 2'b11, 64'h88, 64'h1010, 3'b101, 3'b100, 5'd9, 5'd8, 5'd8,
                64'h90, 64'h80, 64'h22, 1'b1, 64'h22, 64'h1010};
    vecs[6] = '{5'd12, 5'd12, 2'b11, 64'hC1, 64'hC2, 3'b110, 3'b110, 5'd0, 5'd12, 5'd12,
                64'h0, 64'h121, 64'h212, 1'b1, 64'h121, 64'h121};

    // Reset
    idle();
    rst = 1'b1;
    m_busy = '0; m_ov = 0; m_sbset = 0; m_pc = '0; m_ops = '0; m_req = 0; m_rd = '0;
    m_stall = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_rs_data", out_rs_data, 128'h0);
    chk("rst_out_rd_addr", out_rd_addr, 5'h0);
    chk("rst_out_req_rf", out_req_rf, 1'b0);
    chk("rst_stall", stall_cycles, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // add x3, x1, x2 from the register file
    set_instr(64'h100, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 1'b0);
    rf_rdata = {64'd7, 64'd5};
    step();
    chk("add_valid", out_valid, 1'b1);
    chk("add_ops", out_rs_data, {64'd7, 64'd5});
    chk("add_stall", stall_cycles, 32'd0);

    // Operand resolution table (scoreboard empty, downstream ready)
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      idle();
      set_instr(64'h1000 + 64'(k), vecs[k].rs1, vecs[k].rs2, vecs[k].used, 1'b0, 5'd0, 1'b0);
      rf_rdata = {vecs[k].rf2, vecs[k].rf1};
      set_fw(0, vecs[k].fwv[0], vecs[k].fwr[0], vecs[k].fwa0, vecs[k].fwd0);
      set_fw(1, vecs[k].fwv[1], vecs[k].fwr[1], vecs[k].fwa1, vecs[k].fwd1);
      set_fw(2, vecs[k].fwv[2], vecs[k].fwr[2], vecs[k].fwa2, vecs[k].fwd2);
      #1;
      chk("vec_ready", in_ready, vecs[k].exp_rdy);
      step();
      if (vecs[k].exp_rdy) chk("vec_ops", out_rs_data, {vecs[k].exp2, vecs[k].exp1});
    end

    // fw0 not ready stalls, then its ready rise lets the instruction fire
    @(negedge clk);
    idle();
    base = m_stall;
    set_instr(64'h180, 5'd4, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0);
    set_fw(0, 1'b1, 1'b0, 5'd4, 64'hAA);
    set_fw(1, 1'b1, 1'b1, 5'd4, 64'hBB);
    step();
    chk("fwstall_cnt", stall_cycles, base + 32'd1);
    @(negedge clk);
    fw_data_ready[0] = 1'b1;
    step();
    chk("fwready_op", out_rs_data[63:0], 64'hAA);
    chk("fwready_pc", out_pc, 64'h180);

    // Long-latency producer, stalled consumer, wb with write-through
    @(negedge clk);
    idle();
    set_instr(64'h200, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 1'b1);
    step();
    @(negedge clk);
    idle();
    base = m_stall;
    set_instr(64'h204, 5'd6, 5'd0, 2'b01, 1'b1, 5'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_rd_addr = 5'd6; rf_rdata[63:0] = 64'h1234;
    step();
    @(negedge clk);
    wb_valid = 1'b0;
    step();
    chk("ll_valid", out_valid, 1'b1);
    chk("ll_pc", out_pc, 64'h204);
    chk("ll_op", out_rs_data[63:0], 64'h1234);
    chk("ll_stall", stall_cycles, base + 32'd4);

    // Flush of a long-latency writer releases its scoreboard bit
    @(negedge clk);
    idle();
    set_instr(64'h300, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 1'b1);
    step();
    @(negedge clk);
    idle();
    flush = 1'b1;
    step();
    chk("flush_valid", out_valid, 1'b0);
    @(negedge clk);
    idle();
    base = m_stall;
    set_instr(64'h304, 5'd6, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0);
    rf_rdata[63:0] = 64'h66;
    step();
    chk("postflush_valid", out_valid, 1'b1);
    chk("postflush_op", out_rs_data[63:0], 64'h66);
    chk("postflush_stall", stall_cycles, base);

    // Backpressure, then handoff and load on the same edge
    @(negedge clk);
    idle();
    step();
    @(negedge clk);
    idle();
    out_ready = 1'b0;
    set_instr(64'h400, 5'd1, 5'd2, 2'b11, 1'b1, 5'd9, 1'b0);
    rf_rdata = {64'h22, 64'h11};
    step();
    @(negedge clk);
    set_instr(64'h404, 5'd3, 5'd0, 2'b01, 1'b1, 5'd10, 1'b0);
    rf_rdata = {64'h0, 64'h33};
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("bp_ready", in_ready, 1'b0);
      step();
      chk("bp_pc", out_pc, 64'h400);
      chk("bp_ops", out_rs_data, {64'h22, 64'h11});
      @(negedge clk);
    end
    out_ready = 1'b1;
    step();
    chk("handoff_valid", out_valid, 1'b1);
    chk("handoff_pc", out_pc, 64'h404);

    // Scoreboard set and wb clear of the same register in one cycle: set wins
    @(negedge clk);
    idle();
    set_instr(64'h500, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 1'b1);
    wb_valid = 1'b1; wb_rd_addr = 5'd7;
    step();
    @(negedge clk);
    idle();
    set_instr(64'h504, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0);
    #1;
    chk("setwins_ready", in_ready, 1'b0);
    step();
    @(negedge clk);
    wb_valid = 1'b1; wb_rd_addr = 5'd7;
    step();
    @(negedge clk);
    wb_valid = 1'b0;
    step();
    chk("setwins_pc", out_pc, 64'h504);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst         = ($urandom % 256) == 0;
      in_valid    = ($urandom % 4) != 0;
      in_pc       = {$urandom, $urandom};
      in_rs_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      in_rs_used  = 2'($urandom);
      in_req_rf   = ($urandom % 4) != 0;
      in_rd_addr  = 5'($urandom_range(0, 7));
      in_long_lat = 1'($urandom);
      flush       = ($urandom % 16) == 0;
      rf_rdata    = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 3; j++)
        set_fw(j, 1'($urandom), ($urandom % 4) != 0, 5'($urandom_range(0, 7)),
               {$urandom, $urandom});
      wb_valid    = ($urandom % 3) == 0;
      wb_rd_addr  = 5'($urandom_range(0, 7));
      out_ready   = ($urandom % 4) != 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
